// File: rtl/ker_bank_writer.sv
// Kernel-SRAM write distributor: drains a FIFO stream into consecutive banks starting at a base address.
// Define KERW_SHIFT_EN to stagger bank writes through a shift pipeline instead of broadcasting FIFO data.
module ker_bank_writer #(
    parameter int DATA_W        = 64,
    parameter int ADDR_CNT_BITS = 10,
    parameter int NUM_BANKS     = 8,
    parameter int BANK_SEL_BITS = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start_ker_write,
    input  logic [ADDR_CNT_BITS-1:0]           cfg_kerw_buflength,
    input  logic [BANK_SEL_BITS-1:0]           cfg_kerw_banks,
    input  logic [ADDR_CNT_BITS-1:0]           cfg_kerw_base,
    input  logic [DATA_W-1:0]                  ker_write_data_din,
    input  logic                               ker_write_empty_n_din,
    output logic                               ker_write_read_dout,
    output logic [NUM_BANKS-1:0]               cen_kersr,
    output logic [NUM_BANKS-1:0]               wen_kersr,
    output logic [NUM_BANKS*ADDR_CNT_BITS-1:0] addr_kersr,
    output logic [NUM_BANKS*DATA_W-1:0]        din_kersr,
    output logic                               ker_write_busy,
    output logic                               ker_write_en,
    output logic                               ker_write_done
);

`ifdef KERW_SHIFT_EN
    localparam int DRAIN_CYCLES = NUM_BANKS - 1;
`else
    localparam int DRAIN_CYCLES = 1;
`endif
    localparam logic [BANK_SEL_BITS-1:0] DRAIN_LAST = BANK_SEL_BITS'(DRAIN_CYCLES - 1);
    localparam logic [BANK_SEL_BITS:0]   NB_FULL    = (BANK_SEL_BITS + 1)'(NUM_BANKS);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FILL, S_DRAIN, S_DONE} state_t;

    state_t                    state;
    logic [ADDR_CNT_BITS-1:0]  len_last;
    logic [ADDR_CNT_BITS-1:0]  base;
    logic [ADDR_CNT_BITS-1:0]  beat_cnt;
    logic [BANK_SEL_BITS-1:0]  nb_last;
    logic [BANK_SEL_BITS-1:0]  bank_idx;
    logic [BANK_SEL_BITS-1:0]  drain_cnt;
    logic                      accept;
    logic                      nb_clamp;
    logic [ADDR_CNT_BITS-1:0]  cur_addr;

    assign accept              = (state == S_FILL) & ker_write_empty_n_din;
    assign ker_write_read_dout = accept;
    assign cur_addr            = base + beat_cnt;
    assign nb_clamp            = (cfg_kerw_banks == '0) || ({1'b0, cfg_kerw_banks} > NB_FULL);

    // Control FSM; busy/en/done are registered alongside the state they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            len_last       <= '0;
            base           <= '0;
            beat_cnt       <= '0;
            nb_last        <= '0;
            bank_idx       <= '0;
            drain_cnt      <= '0;
            ker_write_busy <= 1'b0;
            ker_write_en   <= 1'b0;
            ker_write_done <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_ker_write) begin
                        state          <= S_LOAD;
                        ker_write_busy <= 1'b1;
                    end
                end
                S_LOAD: begin
                    len_last  <= cfg_kerw_buflength - 1'b1;
                    base      <= cfg_kerw_base;
                    nb_last   <= nb_clamp ? BANK_SEL_BITS'(NUM_BANKS - 1) : cfg_kerw_banks - 1'b1;
                    beat_cnt  <= '0;
                    bank_idx  <= '0;
                    drain_cnt <= '0;
                    if (cfg_kerw_buflength == '0) begin
                        state <= S_DRAIN;
                    end else begin
                        state        <= S_FILL;
                        ker_write_en <= 1'b1;
                    end
                end
                S_FILL: begin
                    if (accept) begin
                        if (beat_cnt == len_last) begin
                            beat_cnt <= '0;
                            if (bank_idx == nb_last) begin
                                state        <= S_DRAIN;
                                ker_write_en <= 1'b0;
                            end else begin
                                bank_idx <= bank_idx + 1'b1;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state          <= S_DONE;
                        ker_write_done <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    state          <= S_IDLE;
                    ker_write_done <= 1'b0;
                    ker_write_busy <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Tap k is the {valid, bank, addr, data} view seen by bank k.
    logic                     tap_valid [NUM_BANKS];
    logic [BANK_SEL_BITS-1:0] tap_bank  [NUM_BANKS];
    logic [ADDR_CNT_BITS-1:0] tap_addr  [NUM_BANKS];
    logic [DATA_W-1:0]        tap_data  [NUM_BANKS];

`ifdef KERW_SHIFT_EN
    logic                     pipe_valid [1:NUM_BANKS-1];
    logic [BANK_SEL_BITS-1:0] pipe_bank  [1:NUM_BANKS-1];
    logic [ADDR_CNT_BITS-1:0] pipe_addr  [1:NUM_BANKS-1];
    logic [DATA_W-1:0]        pipe_data  [1:NUM_BANKS-1];

    // Each stage delays the accepted beat by one more cycle so bank k sees it k cycles late.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 1; k < NUM_BANKS; k++) begin
                pipe_valid[k] <= 1'b0;
                pipe_bank[k]  <= '0;
                pipe_addr[k]  <= '0;
                pipe_data[k]  <= '0;
            end
        end else begin
            for (int k = 1; k < NUM_BANKS; k++) begin
                pipe_valid[k] <= tap_valid[k-1];
                pipe_bank[k]  <= tap_bank[k-1];
                pipe_addr[k]  <= tap_addr[k-1];
                pipe_data[k]  <= tap_data[k-1];
            end
        end
    end

    always_comb begin
        tap_valid[0] = accept;
        tap_bank[0]  = bank_idx;
        tap_addr[0]  = cur_addr;
        tap_data[0]  = ker_write_data_din;
        for (int k = 1; k < NUM_BANKS; k++) begin
            tap_valid[k] = pipe_valid[k];
            tap_bank[k]  = pipe_bank[k];
            tap_addr[k]  = pipe_addr[k];
            tap_data[k]  = pipe_data[k];
        end
    end
`else
    always_comb begin
        for (int k = 0; k < NUM_BANKS; k++) begin
            tap_valid[k] = accept;
            tap_bank[k]  = bank_idx;
            tap_addr[k]  = cur_addr;
            tap_data[k]  = ker_write_data_din;
        end
    end
`endif

    // Only the bank addressed by its tap is enabled; all others rest at cen=1, addr=0, din=0.
    always_comb begin
        cen_kersr  = '1;
        addr_kersr = '0;
        din_kersr  = '0;
        for (int k = 0; k < NUM_BANKS; k++) begin
            if (tap_valid[k] && (tap_bank[k] == BANK_SEL_BITS'(k))) begin
                cen_kersr[k]                                  = 1'b0;
                addr_kersr[k*ADDR_CNT_BITS +: ADDR_CNT_BITS]  = tap_addr[k];
                din_kersr[k*DATA_W +: DATA_W]                 = tap_data[k];
            end
        end
    end

    assign wen_kersr = cen_kersr;

endmodule

// File: tb/tb_ker_bank_writer.sv
// Self-checking bench for ker_bank_writer: random jobs, FIFO model, and a write scoreboard.
// Honours KERW_SHIFT_EN for the expected drain length.
module tb_ker_bank_writer;

    localparam int DATA_W = 64;
    localparam int A      = 10;
    localparam int NB     = 8;
    localparam int BS     = 4;
`ifdef KERW_SHIFT_EN
    localparam int D = NB - 1;
`else
    localparam int D = 1;
`endif

    typedef struct packed {
        logic [BS-1:0]     bank;
        logic [A-1:0]      addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic                   clk;
    logic                   reset;
    logic                   start_ker_write;
    logic [A-1:0]           cfg_kerw_buflength;
    logic [BS-1:0]          cfg_kerw_banks;
    logic [A-1:0]           cfg_kerw_base;
    logic [DATA_W-1:0]      ker_write_data_din;
    logic                   ker_write_empty_n_din;
    logic                   ker_write_read_dout;
    logic [NB-1:0]          cen_kersr;
    logic [NB-1:0]          wen_kersr;
    logic [NB*A-1:0]        addr_kersr;
    logic [NB*DATA_W-1:0]   din_kersr;
    logic                   ker_write_busy;
    logic                   ker_write_en;
    logic                   ker_write_done;

    ker_bank_writer #(
        .DATA_W(DATA_W), .ADDR_CNT_BITS(A), .NUM_BANKS(NB), .BANK_SEL_BITS(BS)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start_ker_write(start_ker_write),
        .cfg_kerw_buflength(cfg_kerw_buflength),
        .cfg_kerw_banks(cfg_kerw_banks),
        .cfg_kerw_base(cfg_kerw_base),
        .ker_write_data_din(ker_write_data_din),
        .ker_write_empty_n_din(ker_write_empty_n_din),
        .ker_write_read_dout(ker_write_read_dout),
        .cen_kersr(cen_kersr),
        .wen_kersr(wen_kersr),
        .addr_kersr(addr_kersr),
        .din_kersr(din_kersr),
        .ker_write_busy(ker_write_busy),
        .ker_write_en(ker_write_en),
        .ker_write_done(ker_write_done)
    );

    logic [DATA_W-1:0] fifo_q[$];
    wr_t               exp_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pops = 0;
    int last_acc = -1;
    int done_cnt = 0;
    int done_cyc = -1;
    int feed_mode = 0;
    int pat = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // FIFO model: presents the head word, pops it whenever the DUT accepts just before the edge.
    initial begin
        ker_write_empty_n_din = 1'b0;
        ker_write_data_din    = '0;
        forever begin
            logic avail;
            @(negedge clk);
            case (feed_mode)
                1:       avail = (pat % 4 == 0) || (pat % 4 == 3);
                2:       avail = ($urandom % 2) == 1;
                default: avail = 1'b1;
            endcase
            pat++;
            ker_write_empty_n_din = avail && (fifo_q.size() > 0);
            ker_write_data_din    = (fifo_q.size() > 0) ? fifo_q[0] : '0;
            #4;
            if (ker_write_read_dout === 1'b1) begin
                if (fifo_q.size() > 0) void'(fifo_q.pop_front());
                pops++;
                last_acc = cyc;
            end
        end
    end

    // Monitor: every enabled bank write is popped from the scoreboard and compared.
    initial begin
        forever begin
            int   nlow;
            logic idle_ok;
            wr_t  e;
            @(negedge clk);
            #4;
            if (reset) continue;
            if (ker_write_done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
            nlow    = 0;
            idle_ok = 1'b1;
            for (int k = 0; k < NB; k++) begin
                if (cen_kersr[k] === 1'b0) begin
                    nlow++;
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_write_bank", k, 128'hdead);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("wr_bank", k, e.bank);
                        checkOutput("wr_addr", addr_kersr[k*A +: A], e.addr);
                        checkOutput("wr_data", din_kersr[k*DATA_W +: DATA_W], e.data);
                    end
                end else if (addr_kersr[k*A +: A] !== '0 || din_kersr[k*DATA_W +: DATA_W] !== '0) begin
                    idle_ok = 1'b0;
                end
            end
            checkOutput("idle_banks_zero", idle_ok, 1'b1);
            checkOutput("wen_eq_cen", wen_kersr, cen_kersr);
            if (nlow > 1) checkOutput("single_write_per_cycle", nlow, 1);
        end
    end

    // Reference model: beats go bank by bank, addresses (base+i) mod 2^A, data in FIFO order.
    task automatic loadJob(input int len, input int nbc, input int base);
        logic [DATA_W-1:0] w;
        wr_t e;
        fifo_q.delete();
        exp_q.delete();
        for (int b = 0; b < nbc; b++) begin
            for (int i = 0; i < len; i++) begin
                w = {$urandom, $urandom};
                fifo_q.push_back(w);
                e.bank = BS'(b);
                e.addr = A'((base + i) % (1 << A));
                e.data = w;
                exp_q.push_back(e);
            end
        end
        for (int i = 0; i < 3; i++) fifo_q.push_back({$urandom, $urandom});
        pops     = 0;
        done_cnt = 0;
        done_cyc = -1;
        last_acc = -1;
    endtask

    task automatic applyStimulus(input int len, input int nbcfg, input int base, input int mode, input bit extra_start);
        int nbc;
        int s;
        int drop;
        int timeout;
        int done_exp;
        nbc = (nbcfg == 0 || nbcfg > NB) ? NB : nbcfg;
        $display("[TB] job len=%0d nb=%0d base=%0d mode=%0d", len, nbcfg, base, mode);
        loadJob(len, nbc, base);
        feed_mode = mode;
        @(negedge clk);
        cfg_kerw_buflength = A'(len);
        cfg_kerw_banks     = BS'(nbcfg);
        cfg_kerw_base      = A'(base);
        start_ker_write    = 1'b1;
        s = cyc;
        @(negedge clk);
        start_ker_write = 1'b0;
        #1;
        checkOutput("busy_in_load", ker_write_busy, 1'b1);
        @(negedge clk);
        cfg_kerw_buflength = A'($urandom);
        cfg_kerw_banks     = BS'($urandom);
        cfg_kerw_base      = A'($urandom);
        #1;
        checkOutput("en_after_load", ker_write_en, (len > 0));
        if (extra_start) begin
            repeat (3) @(negedge clk);
            start_ker_write = 1'b1;
            @(negedge clk);
            start_ker_write = 1'b0;
            #1;
        end
        timeout = 0;
        while (ker_write_busy === 1'b1 && timeout < 5000) begin
            @(negedge clk);
            #1;
            timeout++;
        end
        checkOutput("busy_timeout", (timeout >= 5000), 1'b0);
        drop = cyc;
        done_exp = (len == 0) ? s + 2 + D : last_acc + 1 + D;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("stays_idle", ker_write_busy, 1'b0);
        checkOutput("done_cycle", done_cyc, done_exp);
        checkOutput("done_width", done_cnt, 1);
        checkOutput("busy_drop_cycle", drop, done_exp + 1);
        checkOutput("pop_count", pops, len * nbc);
        checkOutput("writes_missing", exp_q.size(), 0);
        checkOutput("fifo_leftover", fifo_q.size(), 3);
        feed_mode = 0;
    endtask

    task automatic resetMidFill();
        $display("[TB] reset during fill");
        loadJob(4, NB, 0);
        feed_mode = 0;
        @(negedge clk);
        cfg_kerw_buflength = A'(4);
        cfg_kerw_banks     = BS'(NB);
        cfg_kerw_base      = '0;
        start_ker_write    = 1'b1;
        @(negedge clk);
        start_ker_write = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        checkOutput("pre_reset_filling", ker_write_en, 1'b1);
        reset = 1'b1;
        #1;
        checkOutput("rst_cen", cen_kersr, {NB{1'b1}});
        checkOutput("rst_read", ker_write_read_dout, 1'b0);
        checkOutput("rst_busy", ker_write_busy, 1'b0);
        checkOutput("rst_en", ker_write_en, 1'b0);
        exp_q.delete();
        fifo_q.delete();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("post_reset_cen", cen_kersr, {NB{1'b1}});
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset              = 1'b1;
        start_ker_write    = 1'b0;
        cfg_kerw_buflength = '0;
        cfg_kerw_banks     = '0;
        cfg_kerw_base      = '0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_read", ker_write_read_dout, 1'b0);
        checkOutput("reset_busy", ker_write_busy, 1'b0);
        checkOutput("reset_en", ker_write_en, 1'b0);
        checkOutput("reset_done", ker_write_done, 1'b0);
        checkOutput("reset_cen", cen_kersr, {NB{1'b1}});
        checkOutput("reset_wen", wen_kersr, {NB{1'b1}});
        checkOutput("reset_addr", (addr_kersr == '0), 1'b1);
        checkOutput("reset_din", (din_kersr == '0), 1'b1);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        applyStimulus(4, 8, 0, 0, 1'b0);
        applyStimulus(3, 2, 1022, 0, 1'b0);
        applyStimulus(5, 3, 17, 1, 1'b0);
        applyStimulus(0, 5, 3, 0, 1'b0);
        applyStimulus(3, 0, 100, 2, 1'b1);
        applyStimulus(2, 11, 1020, 1, 1'b0);
        resetMidFill();
        applyStimulus(2, 4, 500, 2, 1'b0);
        for (int j = 0; j < 6; j++) begin
            applyStimulus($urandom_range(1, 6), $urandom_range(0, 15), $urandom_range(0, 1023),
                          $urandom_range(0, 2), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ker_bank_writer.md
# ker_bank_writer

Parametrised kernel-SRAM write distributor. Drains a 64-bit-style FIFO stream, one beat per cycle, into `cfg_kerw_banks` consecutive kernel SRAM banks. Bank 0 receives the first `cfg_kerw_buflength` beats, bank 1 the next block, and so on. Writes start at a configurable base address. Sits between the kernel FIFO read mux and the kernel SRAM top, under `schedule_ctrl` start/done control. Bank count, data width and address width are generic. Staggered or broadcast write fan-out is selected at compile time.

## Interface
- `DATA_W`, 64, SRAM word / FIFO data width
- `ADDR_CNT_BITS`, 10, SRAM address width
- `NUM_BANKS`, 8, physical bank count, legal 2..16
- `BANK_SEL_BITS`, 4, width of bank index/config, must satisfy 2^BANK_SEL_BITS ≥ NUM_BANKS
- `clk`  in  1  clock; single clock domain
- `reset`  in  1  asynchronous, active-high reset
- `start_ker_write`  in  1  start pulse, sampled in IDLE only
- `cfg_kerw_buflength`  in  ADDR_CNT_BITS  beats per bank
- `cfg_kerw_banks`  in  BANK_SEL_BITS  banks to fill
- `cfg_kerw_base`  in  ADDR_CNT_BITS  first address in every bank
- `ker_write_data_din`  in  DATA_W  FIFO data
- `ker_write_empty_n_din`  in  1  FIFO not-empty
- `ker_write_read_dout`  out  1  FIFO pop
- `cen_kersr`  out  NUM_BANKS  per-bank chip enable, active-low
- `wen_kersr`  out  NUM_BANKS  per-bank write enable, active-low, equal to `cen_kersr`
- `addr_kersr`  out  NUM_BANKS*ADDR_CNT_BITS  per-bank address; bank k occupies slice [k*ADDR_CNT_BITS +: ADDR_CNT_BITS]
- `din_kersr`  out  NUM_BANKS*DATA_W  per-bank write data; bank k occupies slice [k*DATA_W +: DATA_W]
- `ker_write_busy`  out  1  high in every state except IDLE
- `ker_write_en`  out  1  high in FILL
- `ker_write_done`  out  1  one-cycle pulse in DONE

## Operation
- **FSM states:** IDLE, LOAD, FILL, DRAIN, DONE.
  - IDLE → LOAD on `start_ker_write`. A start in any other state is ignored.
  - LOAD (1 cycle): latches `len = cfg_kerw_buflength`, `nb = cfg_kerw_banks`, `base = cfg_kerw_base`.
    - `nb` of 0 or greater than NUM_BANKS is clamped to NUM_BANKS.
    - If `len == 0`, go to DRAIN and perform no writes. Otherwise go to FILL with `bank_idx = 0` and `beat_cnt = 0`.
  - FILL → DRAIN on the accept of the last beat, i.e. `bank_idx == nb-1` and `beat_cnt == len-1`.
  - DRAIN lasts D cycles, then → DONE. D is defined under Configuration.
  - DONE (1 cycle) → IDLE.
- **FIFO pop:** `ker_write_read_dout = (state==FILL) & ker_write_empty_n_din`. This is combinational. Accept = pop. Never pops outside FILL; no overshoot past the last beat.
- **Counters:**
  - On each accept, `beat_cnt` increments.
  - At `len-1`, `beat_cnt` clears and `bank_idx` increments.
  - With no accept, both counters hold (stall).
- **Address:** `(base + beat_cnt)` mod 2^ADDR_CNT_BITS. Wrap-around is silent.
- **Per-bank outputs:** for each accepted beat, exactly one write to bank `bank_idx` with the address above and the accepted data.
- **Idle outputs:** any bank not being written has `cen`/`wen` = 1, addr = 0 and din = 0.
- **Reset values:** `ker_write_read_dout`, `ker_write_busy`, `ker_write_en` and `ker_write_done` = 0. All `cen_kersr`/`wen_kersr` bits = 1. All addr/din = 0. FSM = IDLE.
- **Reset mid-operation:** immediate return to reset values. Pipeline contents are discarded and no further writes issue.
- Config inputs are only sampled in LOAD. Changes during busy have no effect.

## Timing
- `start_ker_write` at cycle S → LOAD at S+1 → FILL at S+2. The earliest pop is at S+2.
- The accept of the final beat at cycle T → DRAIN at T+1 → DONE at T+1+D. `ker_write_done` is high only in that cycle. `busy` drops at T+2+D.
- Without shift (see Configuration), a bank write occurs in the same cycle as its accept.
- With shift, bank k's write occurs exactly k cycles after its accept, using registered address and data.

## Configuration
- `KERW_SHIFT_EN` **defined:** each accept enters a NUM_BANKS-1 deep shift pipeline of {valid, bank_idx, addr, data}. Bank k drives from stage k, and stage 0 is combinational from the accept. This reduces fan-out of the FIFO data. D = NUM_BANKS-1.
- `KERW_SHIFT_EN` **undefined:** all banks are driven directly from the accept path (broadcast with per-bank enable). D = 1.

## Test plan
- NUM_BANKS=8, len=4, nb=8, base=0, FIFO always non-empty → exactly 32 pops. Bank k receives addrs 0..3 with data 4k..4k+3. `done` at T+1+D.
- len=3, nb=2, base=1022 (ADDR_CNT_BITS=10) → bank 0 writes addrs 1022, 1023, 0. Bank 1 writes the same addrs. No writes reach banks 2..7.
- `empty_n` toggled 1,0,0,1,… → counters hold on the 0 cycles. The total write count equals `len*nb`, and the data order is preserved.
- len=0 → no pops and no `cen` low. `done` arrives at S+2+D.
- nb=0 → clamped; all 8 banks are written. A `start` pulsed while busy is ignored.
- Reset asserted mid-FILL → all `cen`=1, `read_dout`=0 and `busy`=0 in the same cycle. A new start afterwards completes normally.
